// File: rtl/detect_log_pkg.sv
// Shared definitions for the detection event logger.
//
// A log entry is laid out as {[kind], code[1:0], timestamp[TS_W-1:0]}.
// The kind bit exists only when DETECT_LOG_MODE_CHANGE_EN is defined. With
// that macro, pattern-select changes are logged alongside detections.
// Without it, entries carry only code and timestamp.
package detect_log_pkg;

    localparam logic KIND_DETECT = 1'b0;
    localparam logic KIND_MODE   = 1'b1;

    localparam int CODE_W = 2;

`ifdef DETECT_LOG_MODE_CHANGE_EN
    localparam int KIND_W = 1;
`else
    localparam int KIND_W = 0;
`endif

    // Field offsets within an entry. The timestamp always sits at bit 0.
    // The code field and the kind field follow it.
    localparam int TS_LSB = 0;

    localparam logic [CODE_W-1:0] PAT_00 = 2'b00;
    localparam logic [CODE_W-1:0] PAT_01 = 2'b01;
    localparam logic [CODE_W-1:0] PAT_10 = 2'b10;
    localparam logic [CODE_W-1:0] PAT_11 = 2'b11;

    function automatic int entry_w(input int ts_w);
        return ts_w + CODE_W + KIND_W;
    endfunction

    function automatic int code_lsb(input int ts_w);
        return TS_LSB + ts_w;
    endfunction

    function automatic int kind_lsb(input int ts_w);
        return TS_LSB + ts_w + CODE_W;
    endfunction

endpackage

// File: rtl/detect_event_logger_fifo.sv
// log_sync_fifo: synchronous first-word-fall-through FIFO with a registered
// head register.
//
// Ports:
//   i_clk, i_srst        clock, synchronous active-high reset
//   i_wr_en, i_wr_data   write request and data
//   o_wr_accept          the write is taken this cycle. Either the FIFO is
//                        not full, or a read frees a slot in the same cycle.
//   i_rd_ready           consumer accepts the head entry
//   o_rd_valid           head entry valid (== !empty)
//   o_rd_data            registered head entry
//   o_count, o_full, o_empty  occupancy, kept as an explicit counter
module log_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_wr_accept,
    input  logic                     i_rd_ready,
    output logic                     o_rd_valid,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_empty;
    logic             w_full;
    logic             w_do_read;
    logic             w_do_write;
    logic [AW-1:0]    w_rd_ptr_inc;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    // No handshake completes while reset is high, and reads of an empty FIFO
    // are ignored.
    assign w_do_read    = !w_empty && i_rd_ready && !i_srst;
    assign w_do_write   = i_wr_en && (!w_full || w_do_read) && !i_srst;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    // Storage array without reset, so that block RAM can be inferred.
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_read) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // The head register is loaded from the incoming word in two cases.
            // One is when the FIFO is empty. The other is when the only stored
            // word is being popped. Otherwise, on a pop, the head register is
            // loaded from the next stored slot. That slot is always already
            // written when count >= 2.
            if (w_do_write && (w_empty || (w_do_read && r_count == CW'(1)))) begin
                r_rd_data <= i_wr_data;
            end else if (w_do_read && r_count != CW'(1)) begin
                r_rd_data <= r_mem[w_rd_ptr_inc];
            end
        end
    end

    assign o_wr_accept = w_do_write;
    assign o_rd_valid  = !w_empty;
    assign o_rd_data   = r_rd_data;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule

// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps rising edges of the sequence detector's
// seq_detected flag and queues them for a host over a valid/ready port.
//
// Configuration macro: DETECT_LOG_MODE_CHANGE_EN. When it is defined,
// changes of lookfor_seq are logged as kind=1 entries and rd_data gains a
// kind bit.
//
// Ports:
//   Clock, reset           clock and synchronous active-high reset
//   seq_detected           detection level from the detector
//   lookfor_seq[1:0]       active pattern code
//   rd_ready               consumer accepts head entry
//   rd_valid, rd_data      head entry, laid out as {[kind], code, timestamp}
//   fifo_count/full/empty  occupancy
//   overflow_count[15:0]   saturating count of dropped entries
module detect_event_logger
    import detect_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                        Clock,
    input  logic                        reset,
    input  logic                        seq_detected,
    input  logic [CODE_W-1:0]           lookfor_seq,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [entry_w(TS_W)-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [15:0]                 overflow_count
);

    localparam int EW = entry_w(TS_W);

    logic [TS_W-1:0] r_ts;
    logic            r_prev;
    logic [15:0]     r_ovf;

    logic            w_event;
    logic            w_wr_en;
    logic [EW-1:0]   w_wr_data;
    logic            w_wr_accept;

    assign w_event = seq_detected && !r_prev;

`ifdef DETECT_LOG_MODE_CHANGE_EN
    logic [CODE_W-1:0] r_code;
    logic              r_pend;
    logic [EW-1:0]     r_pend_entry;
    logic              w_pend_next;
    logic [EW-1:0]     w_pend_entry_next;
    logic              w_mode_chg;
    logic [EW-1:0]     w_mode_entry;

    assign w_mode_chg   = (lookfor_seq != r_code);
    assign w_mode_entry = {KIND_MODE, lookfor_seq, r_ts};

    // Only one entry is written per cycle. A detection always goes first.
    // A pending mode entry goes next, and a fresh change goes last. A change
    // that cannot be written this cycle is parked in the pending slot. A
    // further change replaces whatever is parked there. A pending entry is
    // attempted exactly once. If the FIFO is full at that point, the entry
    // is dropped and counted like any other write.
    always_comb begin
        w_wr_en           = 1'b0;
        w_wr_data         = {KIND_DETECT, lookfor_seq, r_ts};
        w_pend_next       = r_pend;
        w_pend_entry_next = r_pend_entry;
        if (w_event) begin
            w_wr_en = 1'b1;
            if (w_mode_chg) begin
                w_pend_next       = 1'b1;
                w_pend_entry_next = w_mode_entry;
            end
        end else if (r_pend) begin
            w_wr_en     = 1'b1;
            w_wr_data   = r_pend_entry;
            w_pend_next = w_mode_chg;
            if (w_mode_chg) begin
                w_pend_entry_next = w_mode_entry;
            end
        end else if (w_mode_chg) begin
            w_wr_en   = 1'b1;
            w_wr_data = w_mode_entry;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            // Track the code during reset so that the code present on reset
            // release is not itself reported as a change.
            r_code       <= lookfor_seq;
            r_pend       <= 1'b0;
            r_pend_entry <= '0;
        end else begin
            r_code       <= lookfor_seq;
            r_pend       <= w_pend_next;
            r_pend_entry <= w_pend_entry_next;
        end
    end
`else
    always_comb begin
        w_wr_en   = w_event;
        w_wr_data = {lookfor_seq, r_ts};
    end
`endif

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_ts   <= '0;
            r_prev <= 1'b0;
            r_ovf  <= '0;
        end else begin
            r_ts   <= r_ts + TS_W'(1);
            r_prev <= seq_detected;
            if (w_wr_en && !w_wr_accept && r_ovf != 16'hFFFF) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    log_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (Clock),
        .i_srst      (reset),
        .i_wr_en     (w_wr_en),
        .i_wr_data   (w_wr_data),
        .o_wr_accept (w_wr_accept),
        .i_rd_ready  (rd_ready),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign overflow_count = r_ovf;

endmodule
